// File: rtl/imem_loader_ctrl_if.sv
// rtl/imem_loader_ctrl_if.sv - byte stream and memory write port bundle for imem_loader_ctrl
//
// Purpose: groups the serial byte handshake and the instruction-memory
// write port seen by the loader controller.
// Signals:
//   rx_valid, rx_data[7:0]  byte offered by the serial front end
//   rx_ready                loader accepts a byte this cycle
//   mem_we                  one-cycle write strobe per assembled word
//   mem_waddr[AW-1:0]       word address of the write
//   mem_wdata[31:0]         assembled little-endian word
// Modports: master = stream source / memory side, slave = loader controller.

interface imem_loader_ctrl_if #(
  parameter int AW = 8
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// rtl/imem_loader_ctrl.sv - boot/reload controller for the instruction memory
//
// Purpose: receives a length-prefixed byte stream (N as 16-bit LE, then 4*N
// bytes), assembles little-endian 32-bit words, writes word i to address i,
// stalls the core during the load and pulses pc_reset when it is released.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle request for a new load session (RUN/ERR only)
//   bus (slave)       rx_valid/rx_data/rx_ready stream in, mem_we/mem_waddr/mem_wdata out
//   cpu_stall         core must not fetch or retire (all states except RUN)
//   pc_reset          one-cycle pulse on entry to RUN after a load
//   load_done         last session completed
//   load_err          last session rejected for a bad length
//   word_cnt[AW:0]    words written in the current or last session

module imem_loader_ctrl #(
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter int BOOT_LOAD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  imem_loader_ctrl_if.slave   bus,
  output logic                cpu_stall,
  output logic                pc_reset,
  output logic                load_done,
  output logic                load_err,
  output logic [AW:0]         word_cnt
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam state_t RST_STATE = (BOOT_LOAD != 0) ? ST_LEN0 : ST_RUN;

  state_t        state_q, state_d;
  logic [7:0]    len_lo_q;
  logic [AW:0]   len_q;
  logic [AW:0]   word_idx_q;
  logic [1:0]    byte_idx_q;
  logic [23:0]   asm_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_waddr_q;
  logic [31:0]   mem_wdata_q;
  logic          pc_reset_q;
  logic          load_done_q;

  logic          rx_ready;
  logic          accept;
  logic [15:0]   n_full;
  logic          len_bad;
  logic [AW:0]   word_nxt;
  logic          last_byte;

  // Ready depends on state only, so nothing combinational leaks from rx_valid.
  assign rx_ready = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA);
  assign accept   = bus.rx_valid && rx_ready;

  // Full 16-bit compare so lengths like 0x0101 are rejected, not truncated.
  assign n_full   = {bus.rx_data, len_lo_q};
  assign len_bad  = (n_full == 16'd0) || ({1'b0, n_full} > 17'(DEPTH));

  assign word_nxt  = word_idx_q + {{AW{1'b0}}, 1'b1};
  assign last_byte = (byte_idx_q == 2'd3) && (word_nxt == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (start) state_d = ST_LEN0;
      ST_LEN0:  if (accept) state_d = ST_LEN1;
      ST_LEN1:  if (accept) state_d = len_bad ? ST_ERR : ST_DATA;
      ST_DATA:  if (accept && last_byte) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      ST_ERR:   if (start) state_d = ST_LEN0;
      default:  state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q    <= '0;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      pc_reset_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      // FLUSH always exits to RUN, so this yields exactly one pulse per load.
      pc_reset_q <= (state_q == ST_FLUSH);
      case (state_q)
        ST_RUN: begin
          if (start) begin
            word_idx_q  <= '0;
            load_done_q <= 1'b0;
          end
        end
        ST_ERR: begin
          if (start) word_idx_q <= '0;
        end
        ST_LEN0: begin
          if (accept) len_lo_q <= bus.rx_data;
        end
        ST_LEN1: begin
          if (accept && !len_bad) begin
            len_q      <= n_full[AW:0];
            word_idx_q <= '0;
            byte_idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (accept) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= bus.rx_data;
              2'd1: asm_q[15:8]  <= bus.rx_data;
              2'd2: asm_q[23:16] <= bus.rx_data;
              default: begin
                mem_wdata_q <= {bus.rx_data, asm_q};
                mem_waddr_q <= word_idx_q[AW-1:0];
                mem_we_q    <= 1'b1;
                word_idx_q  <= word_nxt;
              end
            endcase
          end
        end
        ST_FLUSH: load_done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_stall     = (state_q != ST_RUN);
  assign pc_reset      = pc_reset_q;
  assign load_done     = load_done_q;
  assign load_err      = (state_q == ST_ERR);
  assign word_cnt      = word_idx_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb/tb_imem_loader_ctrl.sv - self-checking bench for imem_loader_ctrl

module tb_imem_loader_ctrl;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na, rst_nb, start_a, start_b;
  logic stall_a, pcr_a, done_a, err_a;
  logic stall_b, pcr_b, done_b, err_b;
  logic [AW:0] cnt_a, cnt_b;

  imem_loader_ctrl_if #(.AW(AW)) bus_a ();
  imem_loader_ctrl_if #(.AW(AW)) bus_b ();

  imem_loader_ctrl #(.DEPTH(256), .AW(AW), .BOOT_LOAD(0)) dut_a (
    .clk(clk), .rst_n(rst_na), .start(start_a), .bus(bus_a.slave),
    .cpu_stall(stall_a), .pc_reset(pcr_a), .load_done(done_a),
    .load_err(err_a), .word_cnt(cnt_a)
  );

  imem_loader_ctrl #(.DEPTH(256), .AW(AW), .BOOT_LOAD(1)) dut_b (
    .clk(clk), .rst_n(rst_nb), .start(start_b), .bus(bus_b.slave),
    .cpu_stall(stall_b), .pc_reset(pcr_b), .load_done(done_b),
    .load_err(err_b), .word_cnt(cnt_b)
  );

  typedef struct {
    logic [15:0] n;
    bit          gaps;
    bit          exp_err;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs [7];

  logic [AW-1:0] la_addr[$];
  logic [31:0]   la_data[$];
  logic [AW-1:0] lb_addr[$];
  logic [31:0]   lb_data[$];
  int pc_cnt_a = 0;
  int ready_drops = 0;
  bit in_data = 1'b0;

  int errs = 0;
  int checks = 0;

  always @(negedge clk) begin
    if (bus_a.mem_we) begin
      la_addr.push_back(bus_a.mem_waddr);
      la_data.push_back(bus_a.mem_wdata);
    end
    if (bus_b.mem_we) begin
      lb_addr.push_back(bus_b.mem_waddr);
      lb_data.push_back(bus_b.mem_wdata);
    end
    if (pcr_a) pc_cnt_a++;
    if (in_data && !bus_a.rx_ready) ready_drops++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return 32'(i);
  endfunction

  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) begin
      if (sel) bus_b.rx_valid = 1'b0; else bus_a.rx_valid = 1'b0;
      @(negedge clk);
    end
    if (sel) begin
      bus_b.rx_valid = 1'b1; bus_b.rx_data = b;
    end else begin
      bus_a.rx_valid = 1'b1; bus_a.rx_data = b;
    end
    tries = 0;
    while (!(sel ? bus_b.rx_ready : bus_a.rx_ready) && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_session(input vec_t v);
    logic [31:0] w;
    int gap, bad;
    la_addr.delete(); la_data.delete();
    pc_cnt_a = 0;
    ready_drops = 0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    check("start_stall", 32'(stall_a), 32'd1);
    check("start_done_clr", 32'(done_a), 32'd0);
    check("start_cnt_clr", 32'(cnt_a), 32'd0);
    check("start_err_clr", 32'(err_a), 32'd0);
    check("start_ready", 32'(bus_a.rx_ready), 32'd1);
    send_byte(1'b0, v.n[7:0], v.gaps ? int'($urandom_range(0, 2)) : 0);
    send_byte(1'b0, v.n[15:8], v.gaps ? int'($urandom_range(0, 2)) : 0);
    if (!v.exp_err) begin
      in_data = 1'b1;
      for (int i = 0; i < int'(v.n); i++) begin
        w = exp_word(v, i);
        for (int b = 0; b < 4; b++) begin
          gap = v.gaps ? int'($urandom_range(0, 2)) : 0;
          if (i == int'(v.n) - 1 && b == 3) in_data = 1'b1;
          send_byte(1'b0, w[8*b +: 8], gap);
        end
      end
      in_data = 1'b0;
      bus_a.rx_valid = 1'b0;
      // Last byte just accepted: final write strobe is up, still in FLUSH.
      check("last_we", 32'(bus_a.mem_we), 32'd1);
      check("last_waddr", 32'(bus_a.mem_waddr), 32'(v.n - 16'd1));
      check("flush_stall", 32'(stall_a), 32'd1);
      check("flush_pcr", 32'(pcr_a), 32'd0);
      @(posedge clk); #1;
      check("run_pcr", 32'(pcr_a), 32'd1);
      check("run_stall", 32'(stall_a), 32'd0);
      check("run_done", 32'(done_a), 32'd1);
      check("run_we_low", 32'(bus_a.mem_we), 32'd0);
      repeat (3) @(negedge clk);
      check("write_count", 32'(la_addr.size()), 32'(v.n));
      bad = 0;
      for (int i = 0; i < la_addr.size(); i++)
        if (la_addr[i] !== AW'(i) || la_data[i] !== exp_word(v, i)) bad++;
      check("write_contents", 32'(bad), 32'd0);
      check("pc_pulses", 32'(pc_cnt_a), 32'd1);
      check("word_cnt", 32'(cnt_a), 32'(v.n));
      check("done_hold", 32'(done_a), 32'd1);
      check("err_low", 32'(err_a), 32'd0);
      check("stall_low", 32'(stall_a), 32'd0);
      check("ready_in_data", 32'(ready_drops), 32'd0);
    end else begin
      // rx_valid stays high: ERR must not consume bytes.
      repeat (3) @(negedge clk);
      check("err_ready", 32'(bus_a.rx_ready), 32'd0);
      check("err_flag", 32'(err_a), 32'd1);
      check("err_stall", 32'(stall_a), 32'd1);
      check("err_done", 32'(done_a), 32'd0);
      check("err_writes", 32'(la_addr.size()), 32'd0);
      check("err_cnt", 32'(cnt_a), 32'd0);
      bus_a.rx_valid = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{n: 16'd2,   gaps: 1'b0, exp_err: 1'b0, w0: 32'h0000_0013, w1: 32'h0010_0093};
    vecs[1] = '{n: 16'd2,   gaps: 1'b1, exp_err: 1'b0, w0: 32'h0000_0013, w1: 32'h0010_0093};
    vecs[2] = '{n: 16'd0,   gaps: 1'b0, exp_err: 1'b1, w0: 32'h0,         w1: 32'h0};
    vecs[3] = '{n: 16'd1,   gaps: 1'b0, exp_err: 1'b0, w0: 32'hDEAD_BEEF, w1: 32'h0};
    vecs[4] = '{n: 16'd257, gaps: 1'b0, exp_err: 1'b1, w0: 32'h0,         w1: 32'h0};
    vecs[5] = '{n: 16'd3,   gaps: 1'b1, exp_err: 1'b0, w0: 32'hA5A5_5A5A, w1: 32'h0123_4567};
    vecs[6] = '{n: 16'd256, gaps: 1'b0, exp_err: 1'b0, w0: 32'h0,         w1: 32'h1};

    rst_na = 1'b0; rst_nb = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    bus_a.rx_valid = 1'b0; bus_a.rx_data = 8'h00;
    bus_b.rx_valid = 1'b0; bus_b.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_stall_a", 32'(stall_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_we_a", 32'(bus_a.mem_we), 32'd0);
    check("rst_pcr_a", 32'(pcr_a), 32'd0);
    check("rst_ready_a", 32'(bus_a.rx_ready), 32'd0);
    check("rst_stall_b", 32'(stall_b), 32'd1);
    check("rst_ready_b", 32'(bus_b.rx_ready), 32'd1);
    rst_na = 1'b1; rst_nb = 1'b1;

    // Idle in RUN with a byte offered: nothing consumed, nothing written.
    bus_a.rx_valid = 1'b1; bus_a.rx_data = 8'h55;
    repeat (20) @(negedge clk);
    check("idle_writes", 32'(la_addr.size()), 32'd0);
    check("idle_ready", 32'(bus_a.rx_ready), 32'd0);
    check("idle_stall", 32'(stall_a), 32'd0);
    check("idle_done", 32'(done_a), 32'd0);
    check("idle_pcr", 32'(pc_cnt_a), 32'd0);
    bus_a.rx_valid = 1'b0;

    for (int k = 0; k < 7; k++) run_session(vecs[k]);

    // Reset mid-session on the boot-load instance: 6 data bytes of a 2-word load.
    lb_addr.delete(); lb_data.delete();
    send_byte(1'b1, 8'h02, 0);
    send_byte(1'b1, 8'h00, 0);
    send_byte(1'b1, 8'h11, 0);
    send_byte(1'b1, 8'h22, 0);
    send_byte(1'b1, 8'h33, 0);
    send_byte(1'b1, 8'h44, 0);
    send_byte(1'b1, 8'h55, 0);
    send_byte(1'b1, 8'h66, 0);
    bus_b.rx_valid = 1'b0;
    @(negedge clk);
    check("b_pre_writes", 32'(lb_addr.size()), 32'd1);
    check("b_pre_data", (lb_data.size() > 0) ? lb_data[0] : 32'hX, 32'h4433_2211);
    check("b_pre_cnt", 32'(cnt_b), 32'd1);
    rst_nb = 1'b0;
    #1;
    check("b_rst_we", 32'(bus_b.mem_we), 32'd0);
    check("b_rst_waddr", 32'(bus_b.mem_waddr), 32'd0);
    check("b_rst_wdata", bus_b.mem_wdata, 32'd0);
    check("b_rst_cnt", 32'(cnt_b), 32'd0);
    check("b_rst_stall", 32'(stall_b), 32'd1);
    check("b_rst_ready", 32'(bus_b.rx_ready), 32'd1);
    check("b_rst_done", 32'(done_b), 32'd0);
    check("b_rst_err", 32'(err_b), 32'd0);
    check("b_rst_pcr", 32'(pcr_b), 32'd0);
    @(negedge clk) rst_nb = 1'b1;
    lb_addr.delete(); lb_data.delete();
    send_byte(1'b1, 8'h01, 0);
    send_byte(1'b1, 8'h00, 0);
    send_byte(1'b1, 8'hEF, 0);
    send_byte(1'b1, 8'hBE, 0);
    send_byte(1'b1, 8'hAD, 0);
    send_byte(1'b1, 8'hDE, 0);
    bus_b.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b_writes", 32'(lb_addr.size()), 32'd1);
    check("b_addr", (lb_addr.size() > 0) ? 32'(lb_addr[0]) : 32'hX, 32'd0);
    check("b_data", (lb_data.size() > 0) ? lb_data[0] : 32'hX, 32'hDEAD_BEEF);
    check("b_done", 32'(done_b), 32'd1);
    check("b_stall", 32'(stall_b), 32'd0);
    check("b_cnt", 32'(cnt_b), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
